// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS data-memory access unit with req/ack bus, lane steering and load extension
// Stalls the core from the IDLE cycle of a valid request until DONE; malformed requests retire with Err.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  SizeCtl,
  input  logic        LoadSigned,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [9:0] LP_LIMIT = 10'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic [31:0] r_read_data;
  logic        r_bus_req, r_bus_we;
  logic [29:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [1:0]  r_size, r_off;
  logic        r_signed, r_timeout;
  logic [9:0]  r_cnt;

  logic        w_any, w_misalign, w_err_req, w_valid, w_limit;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_any      = MemRead | MemWrite;
  assign w_misalign = (SizeCtl == 2'b01 && ALUResult[0]) ||
                      (SizeCtl == 2'b10 && ALUResult[1:0] != 2'b00);
  assign w_err_req  = w_any && ((MemRead && MemWrite) || SizeCtl == 2'b11 || w_misalign);
  assign w_valid    = w_any && !w_err_req;
  assign w_limit    = (r_cnt == LP_LIMIT);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteData;
    case (SizeCtl)
      2'b00: begin
        w_be    = 4'b0001 << ALUResult[1:0];
        w_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << ALUResult[1:0];
        w_wdata = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset latched in IDLE, not the live ALUResult.
  always_comb begin
    w_byte = bus_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      2'd3:    w_byte = bus_rdata[31:24];
      default: ;
    endcase
    w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    Stall  = 1'b0;
    Err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          Stall  = 1'b1;
          w_next = S_REQ;
        end else if (w_err_req) begin
          Err = 1'b1;
        end
      end
      S_REQ: begin
        Stall = 1'b1;
        if (bus_ack || w_limit) w_next = S_DONE;
      end
      S_DONE: begin
        Err    = r_timeout;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (reset) begin
      Stall = 1'b0;
      Err   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data <= 32'd0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 30'd0;
      r_bus_be    <= 4'd0;
      r_bus_wdata <= 32'd0;
      r_size      <= 2'd0;
      r_off       <= 2'd0;
      r_signed    <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= 10'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= MemWrite;
            r_bus_addr  <= ALUResult[31:2];
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_size      <= SizeCtl;
            r_off       <= ALUResult[1:0];
            r_signed    <= LoadSigned;
            r_timeout   <= 1'b0;
            r_cnt       <= 10'd0;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 10'd1;
          // An ack in the limit cycle wins over the timeout.
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            if (!r_bus_we) r_read_data <= w_load;
          end else if (w_limit) begin
            r_bus_req <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        S_DONE: begin
          r_timeout <= 1'b0;
          r_cnt     <= 10'd0;
        end
        default: ;
      endcase
    end
  end

  assign ReadData  = r_read_data;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle data-memory access unit sitting directly downstream of the ALU in the single-cycle MIPS datapath. It takes ALUResult as the effective address for lw/lh/lhu/lb/lbu/sw/sh/sb and performs the byte-lane steering and load extension. It runs a request/acknowledge transaction to an external data memory with variable wait states, and stalls the core until the access completes.

## Interface
- TIMEOUT_CYCLES, 255: maximum REQ cycles without bus_ack before the access is aborted; range 1..1023.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  load request; level, held by the core for the whole instruction.
- MemWrite  in  1  store request; level, held for the whole instruction.
- SizeCtl  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- LoadSigned  in  1  1 = sign-extend loads, 0 = zero-extend loads.
- ALUResult  in  32  effective byte address.
- WriteData  in  32  store data (rt); the size-relevant bits are in the LSBs.
- ReadData  out  32  extended load result, registered.
- Stall  out  1  freezes the PC and register-file write while asserted.
- Err  out  1  one-cycle access-error pulse.
- bus_req  out  1  memory request.
- bus_we  out  1  1 = write.
- bus_addr  out  30  word address, equal to ALUResult[31:2].
- bus_be  out  4  byte enables; bit i selects bits [8i+7:8i].
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  memory completion, sampled only in REQ.
- bus_rdata  in  32  read word, valid in the cycle bus_ack = 1.

## Operation
- FSM states: IDLE, REQ, DONE.
- A request exists when exactly one of MemRead/MemWrite is 1.
- An error request exists when:
  - both MemRead and MemWrite are 1, or
  - SizeCtl = 11, or
  - the address is misaligned: half with ALUResult[0] = 1, or word with ALUResult[1:0] != 00.
- IDLE:
  - Valid request: Stall = 1 combinationally. Latch address, size, signedness, direction and data. Next state is REQ.
  - Error request: Err = 1 and Stall = 0. No bus activity; the instruction retires and ReadData is unchanged. Next state stays IDLE.
- REQ:
  - bus_req = 1, and all bus_* outputs are driven from latched values and held stable.
  - Stall = 1.
  - The timeout counter increments each cycle.
  - If bus_ack = 1: capture bus_rdata (loads only); next state is DONE.
  - If the counter reaches TIMEOUT_CYCLES without ack: set the timeout flag, drop bus_req; next state is DONE.
- DONE:
  - Stall = 0, and the core retires the instruction at this edge.
  - ReadData holds the new load value.
  - If the timeout flag is set: Err = 1 and ReadData is unchanged.
  - Next state is IDLE unconditionally. The request levels still asserted in DONE are ignored, so there is no retrigger.
- Byte enables (k = ALUResult[1:0]):
  - byte: 0001 << k
  - half: 0011 << k
  - word: 1111
- bus_wdata:
  - byte: {4{WriteData[7:0]}}
  - half: {2{WriteData[15:0]}}
  - word: WriteData
- Load extraction:
  - byte lane = bus_rdata[8k+7:8k]; half = bus_rdata[8k+15:8k].
  - Extend to 32 bits by LoadSigned: sign-extend from bit 7/15, or zero-fill.
- Stores never modify ReadData.

## Timing
- Reset values:
  - state IDLE, ReadData = 0, timeout counter and flag = 0
  - bus_req = 0, bus_we = 0, bus_be = 0, bus_addr = 0, bus_wdata = 0
  - Stall = 0 and Err = 0 while reset is held
- Reset mid-transaction drops bus_req asynchronously; a pending ack is ignored.
- Minimum access (ack in the first REQ cycle):
  - IDLE cycle: Stall = 1.
  - REQ cycle: bus_req = 1, ack.
  - DONE cycle: Stall = 0.
  - Result: 3 cycles per memory instruction, 2 of them stalled.
- Each additional wait cycle adds 1 to the latency.
- bus_req is registered and asserts on the edge leaving IDLE; it deasserts on the edge where ack is sampled.
- Stall and Err are combinational from state plus inputs, with no registered delay.
- ReadData updates on the REQ→DONE edge and holds until the next successful load.
- A timeout with TIMEOUT_CYCLES = N gives exactly N REQ cycles, then DONE with Err = 1. An ack arriving in the same cycle the limit is reached counts as success.

## Test plan
- Word round trip:
  - sw with WriteData = 0xDEADBEEF at addr 0x100 → bus_be = 1111, bus_addr = 0x40.
  - lw from 0x100 → ReadData = 0xDEADBEEF.
  - Stall is high for exactly 2 cycles with immediate ack.
- Byte/half extension: memory word 0x80FF7F01.
  - lb at offset 3 → 0xFFFFFF80; lbu at offset 3 → 0x00000080.
  - lh at offset 2 → 0xFFFF80FF; lhu at offset 0 → 0x00007F01.
- Store lanes:
  - sb of 0x000000AB at addr 0x...2 → bus_be = 0100, bus_wdata = 0xABABABAB.
  - sh of 0x1234 at addr 0x...2 → bus_be = 1100, bus_wdata = 0x12341234.
- Misaligned and illegal requests: lw at 0x102, lh at 0x101, SizeCtl = 11, or MemRead & MemWrite together → Err pulses for 1 cycle, Stall = 0, bus_req never asserts, ReadData unchanged.
- Wait states and timeout:
  - ack after 5 REQ cycles → Stall high for 6 cycles, and the correct data is captured.
  - TIMEOUT_CYCLES = 4 with no ack → bus_req high for exactly 4 cycles, then DONE with Err = 1 and ReadData unchanged.
- Reset mid-REQ: assert reset asynchronously between edges → bus_req and Stall drop immediately. After release, the FSM is in IDLE and a new lw completes normally.
